// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port 32-bit memory between instruction fetch and the data load/store path.
// Optional misalignment trapping on the data port: define XGRISCV_MISALIGN_CHECK_EN.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [31:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [1:0]            d_size,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic                  d_ack,
   output logic [31:0]           d_rdata,
   output logic                  d_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   input  logic [31:0]           mem_rdata,
   output logic                  stall
);

   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

   state_t      state, state_nxt;
   logic        last_d;
   logic        grant_if, grant_d, d_mis;
   logic [3:0]  d_be;
   logic [31:0] d_wrep;

   // Data is preferred on contention unless it took the previous grant.
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (state == IDLE) begin
         if (d_req && (!if_req || !last_d)) grant_d = 1'b1;
         else if (if_req)                   grant_if = 1'b1;
      end
   end

`ifdef XGRISCV_MISALIGN_CHECK_EN
   always_comb begin
      d_mis = 1'b0;
      case (d_size)
         2'b10:   d_mis = d_addr[0];
         2'b01:   d_mis = 1'b0;
         default: d_mis = (d_addr[1:0] != 2'b00);
      endcase
   end
`else
   assign d_mis = 1'b0;
`endif

   always_comb begin
      d_be   = 4'b1111;
      d_wrep = d_wdata;
      case (d_size)
         2'b01: begin
            d_be   = 4'b0001 << d_addr[1:0];
            d_wrep = {4{d_wdata[7:0]}};
         end
         2'b10: begin
            d_be   = 4'b0011 << {d_addr[1], 1'b0};
            d_wrep = {2{d_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d && !d_mis) state_nxt = D_BUSY;
            else if (grant_if)     state_nxt = IF_BUSY;
         end
         IF_BUSY, D_BUSY: if (mem_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state  <= state_nxt;
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         if (grant_if) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be   <= 4'b1111;
         end else if (grant_d && !d_mis) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= d_be;
            mem_wdata <= d_wrep;
         end else if (grant_d) begin
            // Trapped access completes immediately without touching memory.
            d_ack   <= 1'b1;
            d_rdata <= '0;
            last_d  <= 1'b1;
         end
         if (state != IDLE && mem_ready) begin
            mem_req <= 1'b0;
            if (state == IF_BUSY) begin
               if_ack   <= 1'b1;
               if_rdata <= mem_rdata;
               last_d   <= 1'b0;
            end else begin
               d_ack   <= 1'b1;
               d_rdata <= mem_rdata;
               last_d  <= 1'b1;
            end
         end
      end
   end

`ifdef XGRISCV_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) d_err <= 1'b0;
      else       d_err <= grant_d & d_mis;
   end
`else
   assign d_err = 1'b0;
`endif

   assign stall = (d_req & ~d_ack) | (if_req & ~if_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [1:0]  d_size = 2'b11;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        stall;

   int n_chk = 0;
   int n_fail = 0;

   mem_arbiter #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding memory transaction or none.
   logic        m_busy = 0, m_is_d = 0, m_last_d = 0;
   logic        m_if_ack = 0, m_d_ack = 0, m_err = 0;
   logic        m_we = 0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_if_rd = 0, m_d_rd = 0;
   logic [3:0]  m_be = 0;

   always @(negedge clk) begin
      int n, off;
      logic pick_d, mis;
      chk("mem_req", mem_req, m_busy);
      chk("if_ack", if_ack, m_if_ack);
      chk("d_ack", d_ack, m_d_ack);
      chk("d_err", d_err, m_err);
      chk("stall", stall, (d_req & ~m_d_ack) | (if_req & ~m_if_ack));
      if (m_busy) begin
         chk("mem_we", mem_we, m_we);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_be", mem_be, m_be);
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_if_ack) chk("if_rdata", if_rdata, m_if_rd);
      if (m_d_ack)  chk("d_rdata", d_rdata, m_d_rd);

      // Advance to the state after the coming rising edge; inputs are stable now.
      if (reset) begin
         m_busy = 0; m_last_d = 0; m_if_ack = 0; m_d_ack = 0; m_err = 0;
      end else begin
         m_if_ack = 0; m_d_ack = 0; m_err = 0;
         if (m_busy) begin
            if (mem_ready) begin
               m_busy = 0;
               m_last_d = m_is_d;
               if (m_is_d) begin m_d_ack = 1; m_d_rd = mem_rdata; end
               else begin m_if_ack = 1; m_if_rd = mem_rdata; end
            end
         end else begin
            pick_d = d_req && !(if_req && m_last_d);
            if (pick_d) begin
               n   = (d_size == 2'b01) ? 1 : (d_size == 2'b10) ? 2 : 4;
               off = (n == 1) ? int'(d_addr % 4) : (n == 2) ? int'(d_addr & 2) : 0;
`ifdef XGRISCV_MISALIGN_CHECK_EN
               mis = (d_addr % n) != 0;
`else
               mis = 0;
`endif
               if (mis) begin
                  m_d_ack = 1; m_err = 1; m_d_rd = 0; m_last_d = 1;
               end else begin
                  m_busy = 1; m_is_d = 1; m_we = d_we;
                  m_addr = d_addr - (d_addr % 4);
                  m_be = 4'(((1 << n) - 1) << off);
                  for (int i = 0; i < 4; i++) m_wdata[8*i +: 8] = d_wdata[8*(i % n) +: 8];
               end
            end else if (if_req) begin
               m_busy = 1; m_is_d = 0; m_we = 0;
               m_addr = if_addr - (if_addr % 4);
               m_be = 4'hF;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] seq;
      logic [31:0] hold_addr;
      tick; tick;
      reset = 0;
      chk("rst mem_req", mem_req, 0);
      chk("rst mem_be", mem_be, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst acks", {30'd0, if_ack, d_ack}, 0);

      // Fetch only
      if_req = 1; if_addr = 32'h104; mem_ready = 1; mem_rdata = 32'h00A00093;
      tick;
      chk("fetch mem_addr", mem_addr, 32'h104);
      chk("fetch mem_be", mem_be, 4'hF);
      tick;
      chk("fetch if_ack", if_ack, 1);
      chk("fetch if_rdata", if_rdata, 32'h00A00093);
      if_req = 0; mem_ready = 0;
      tick;

      // Byte store
      d_req = 1; d_we = 1; d_size = 2'b01; d_addr = 32'h2003; d_wdata = 32'h5A;
      tick;
      chk("bst mem_be", mem_be, 4'b1000);
      chk("bst mem_wdata", mem_wdata, 32'h5A5A5A5A);
      chk("bst mem_we", mem_we, 1);
      chk("bst mem_addr", mem_addr, 32'h2000);
      mem_ready = 1;
      tick;
      chk("bst d_ack", d_ack, 1);
      d_req = 0; mem_ready = 0;
      tick;

      // Wait states on a load
      d_req = 1; d_we = 0; d_size = 2'b11; d_addr = 32'h3000;
      tick;
      hold_addr = mem_addr;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("ws mem_req", mem_req, 1);
         chk("ws mem_addr", mem_addr, 32'h3000);
         chk("ws stall", stall, 1);
         chk("ws d_ack", d_ack, 0);
      end
      mem_ready = 1; mem_rdata = 32'hCAFEF00D;
      tick;
      chk("ws d_ack", d_ack, 1);
      chk("ws d_rdata", d_rdata, 32'hCAFEF00D);
      chk("ws stall", stall, 0);
      d_req = 0; mem_ready = 0;
      tick;

      // Reset in the middle of a data transaction
      d_req = 1; d_addr = 32'h4000;
      tick;
      chk("rm mem_req", mem_req, 1);
      reset = 1;
      tick;
      chk("rm mem_req", mem_req, 0);
      chk("rm d_ack", d_ack, 0);
      reset = 0; d_req = 0;
      tick;
      chk("rm d_ack", d_ack, 0);
      if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h13;
      tick; tick;
      chk("rm if_ack", if_ack, 1);
      chk("rm if_rdata", if_rdata, 32'h13);
      if_req = 0; mem_ready = 0;
      tick;

      // Contention with both requests held
      if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_size = 2'b11; d_addr = 32'h90;
      mem_ready = 1;
      seq = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
         if (d_ack)  seq = {seq[27:0], 4'hD};
         if (if_ack) seq = {seq[27:0], 4'h1};
      end
      chk("contention order", seq, 32'h0000D1D1);
      if_req = 0; d_req = 0; mem_ready = 0;
      tick;

      // Misaligned word load
      d_req = 1; d_we = 0; d_size = 2'b11; d_addr = 32'h2002;
      tick;
`ifdef XGRISCV_MISALIGN_CHECK_EN
      chk("mis mem_req", mem_req, 0);
      chk("mis d_ack", d_ack, 1);
      chk("mis d_err", d_err, 1);
      chk("mis d_rdata", d_rdata, 0);
`else
      chk("mis mem_req", mem_req, 1);
      chk("mis mem_addr", mem_addr, 32'h2000);
      chk("mis d_err", d_err, 0);
      mem_ready = 1;
      tick;
`endif
      d_req = 0; mem_ready = 0;
      tick;

      // Randomized traffic; requesters may chain a new request in their ack cycle
      for (int c = 0; c < 4000; c++) begin
         if (if_req ? (if_ack && $urandom_range(1, 0) == 0) : ($urandom_range(2, 0) == 0)) begin
            if_req = 1; if_addr = $urandom;
         end else if (if_req && if_ack) if_req = 0;
         if (d_req ? (d_ack && $urandom_range(1, 0) == 0) : ($urandom_range(2, 0) == 0)) begin
            d_req = 1; d_we = 1'($urandom); d_size = 2'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
         end else if (d_req && d_ack) d_req = 0;
         mem_ready = ($urandom_range(2, 0) != 0);
         mem_rdata = $urandom;
         reset = ($urandom_range(399, 0) == 0);
         tick;
      end
      reset = 0; if_req = 0; d_req = 0; mem_ready = 1;
      tick; tick; tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one single-port, 32-bit unified memory between instruction fetch (IF) and the MEM-stage load/store path of the xgriscv pipeline. It accepts one request at a time and registers it into a memory transaction, using a 3-state FSM. It generates byte enables from the controller's 2-bit size code (w:11, h:10, b:01), returns the read word to the winning requester, and drives the pipeline stall.

## Interface
- ADDR_WIDTH, 32, byte-address width on all address ports
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_WIDTH  fetch byte address; word access, bits [1:0] ignored
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store (memwrite), 0 = load
- d_size  in  2  11 word, 10 half, 01 byte (swhb or lwhb); 00 treated as word
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  32  store data, right-aligned
- d_ack  out  1  one-cycle pulse; d_rdata/d_err valid
- d_rdata  out  32  raw memory word; no lane extraction or sign extension
- d_err  out  1  misaligned access, see Configuration
- mem_req  out  1  memory request, registered
- mem_we  out  1  write strobe, registered
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory completes the transaction in the cycle it is high with mem_req
- mem_rdata  in  32  read data, valid with mem_ready
- stall  out  1  combinational: (d_req & ~d_ack) | (if_req & ~if_ack)

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY. Reset enters IDLE.
- Reset values: mem_req, mem_we, mem_be, if_ack, d_ack and d_err = 0; mem_addr, mem_wdata, if_rdata and d_rdata = 0; last_grant = IF.
- IDLE with only one request pending: that request is captured and the FSM moves to its BUSY state.
- IDLE with both requests pending: D wins, unless last_grant = D, in which case IF wins. last_grant updates on every completion. D can never take two consecutive grants while IF is waiting.
- BUSY: mem_req held high and all mem_* outputs frozen until mem_ready = 1. On that edge: matching ack pulses, rdata <= mem_rdata, mem_req <= 0, FSM returns to IDLE.
- Byte enables:
  - word: mem_be = 1111
  - half: mem_be = 0011 << (2*addr[1])
  - byte: mem_be = 0001 << addr[1:0]
  - IF always uses 1111 with mem_we = 0.
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged.
- A requester that drops its req while its transaction is in BUSY is not cancelled. The ack still pulses and is ignored by the requester.

## Timing
- Acceptance at edge N. mem_req is high from cycle N+1.
- If mem_ready is high in cycle N+k (k ≥ 1), the ack and rdata are valid in cycle N+k+1 for exactly one cycle.
- Minimum request-to-ack latency: 2 cycles.
- No new acceptance occurs in the ack cycle, because the FSM is in IDLE only from that cycle. Back-to-back transactions therefore take a minimum of 2 cycles each.
- stall is combinational from the inputs and the ack registers. It drops in the ack cycle.
- reset asserted mid-transaction: on the next edge the FSM goes to IDLE and mem_req, the acks and d_err clear. The in-flight transaction is abandoned with no ack. Memory must tolerate mem_req dropping before mem_ready.
- mem_ready while in IDLE is ignored.

## Configuration
- XGRISCV_MISALIGN_CHECK_EN defined:
  - A data access is misaligned when it is a word with addr[1:0] != 0, or a half with addr[0] != 0.
  - A misaligned access is accepted but issues no memory transaction.
  - d_ack and d_err pulse together one cycle after acceptance; d_rdata = 0.
  - last_grant updates as for a normal completion.
- XGRISCV_MISALIGN_CHECK_EN undefined:
  - d_err is tied 0.
  - Misaligned addresses are issued as-is; lane shifts use addr bits as above, so a half at addr[0] = 1 uses the same lanes as addr[0] = 0.

## Test plan
- Fetch only: if_req with if_addr = 0x104; mem_ready high on the first mem_req cycle, mem_rdata = 0x00A00093. Required: mem_addr = 0x104, mem_be = 1111, if_ack 2 cycles after request with if_rdata = 0x00A00093.
- Byte store: d_we = 1, d_size = 01, d_addr = 0x2003, d_wdata = 0x5A. Required: mem_be = 1000, mem_wdata = 0x5A5A5A5A, mem_we = 1, mem_addr = 0x2000.
- Contention: if_req and d_req held continuously, mem_ready always 1. Required: grant order D, IF, D, IF; no two consecutive D acks while IF is waiting.
- Wait states: data load with mem_ready low for 3 cycles. Required: mem_* stable throughout, stall high, d_ack exactly one cycle after mem_ready.
- Reset mid-transaction: reset asserted in D_BUSY. Required: mem_req = 0 and FSM in IDLE after one edge; no d_ack; a subsequent if_req is serviced normally.
- Misalignment, macro defined: word load at 0x2002. Required: no mem_req, d_ack = d_err = 1 in cycle N+1, d_rdata = 0. Same stimulus with the macro undefined: mem_req issued and d_err = 0.
